// File: rtl/uart_tx_param.sv
// UART transmitter, ready/valid input; queues into a FIFO_DEPTH FIFO when UART_TX_FIFO_EN is defined, else one holding register.
// First start bit one cycle after an accepted word reaches an idle block; in_ready drops when the queue is full or txEn is low.
module uart_tx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             txEn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_BITS-1:0]             in_data,
  output logic                             tx,
  output logic                             txBusy,
  output logic                             txDone,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rdy_en;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_BITS-1:0]  w_head;
  logic                  w_head_par;
  logic                  w_bit_end;
  logic                  w_stop_end;
  logic                  w_done_nxt;

  assign in_ready   = r_rdy_en && txEn && !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_bit_end  = (r_cnt == CW'(DIV - 1));
  assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_bit == 3'(STOP_BITS - 1));
  // txDone is registered, so it is raised on the edge entering the final stop cycle
  assign w_done_nxt = (r_state == S_STOP) && (r_cnt == CW'(DIV - 2)) && (r_bit == 3'(STOP_BITS - 1));
  assign w_pop      = txEn && !w_empty && ((r_state == S_IDLE) || w_stop_end);
  assign w_head_par = (PARITY == 1) ? ~^w_head : ^w_head;

  assign tx     = r_tx;
  assign txBusy = r_busy;
  assign txDone = r_done;

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;

  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_head     = r_mem[r_rptr];
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (!txEn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
`else
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_vld;

  assign w_full     = r_hold_vld;
  assign w_empty    = !r_hold_vld;
  assign w_head     = r_hold;
  assign fifo_level = LW'(r_hold_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (!txEn) begin
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold     <= in_data;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (!txEn) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_shift <= '0;
        r_par   <= 1'b0;
        r_tx    <= 1'b1;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_done <= w_done_nxt;
        // A pop only happens from IDLE or at the end of the last stop bit, so both share the frame start
        if (w_pop) begin
          r_shift <= w_head;
          r_par   <= w_head_par;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= S_START;
        end else begin
          case (r_state)
            S_IDLE: begin
              r_cnt <= '0;
            end
            S_START: begin
              if (w_bit_end) begin
                r_cnt   <= '0;
                r_bit   <= '0;
                r_tx    <= r_shift[0];
                r_state <= S_DATA;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            S_DATA: begin
              if (w_bit_end) begin
                r_cnt   <= '0;
                r_shift <= r_shift >> 1;
                if (r_bit == 3'(DATA_BITS - 1)) begin
                  r_bit <= '0;
                  if (PARITY != 0) begin
                    r_tx    <= r_par;
                    r_state <= S_PARITY;
                  end else begin
                    r_tx    <= 1'b1;
                    r_state <= S_STOP;
                  end
                end else begin
                  r_bit <= r_bit + 3'd1;
                  r_tx  <= r_shift[1];
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            S_PARITY: begin
              if (w_bit_end) begin
                r_cnt   <= '0;
                r_bit   <= '0;
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            S_STOP: begin
              if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bit == 3'(STOP_BITS - 1)) begin
                  r_bit   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end else begin
                  r_bit <= r_bit + 3'd1;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            default: begin
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8N1, 7E2, 7O2) at DIV=10 against a waveform-level reference model.
module tb_uart_tx_param;

  localparam int DIV = 10;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             txEn;
  logic [2:0]       vld;
  logic [2:0][7:0]  dat;
  logic [2:0]       rdy;
  logic [2:0]       txl;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0][2:0]  lvl;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(50000000), .BAUD(5000000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .txEn(txEn), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(dat[0]), .tx(txl[0]), .txBusy(busy[0]), .txDone(done[0]), .fifo_level(lvl[0]));

  uart_tx_param #(.CLK_FREQ(50000000), .BAUD(5000000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .txEn(txEn), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(dat[1][6:0]), .tx(txl[1]), .txBusy(busy[1]), .txDone(done[1]), .fifo_level(lvl[1]));

  uart_tx_param #(.CLK_FREQ(50000000), .BAUD(5000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .txEn(txEn), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_data(dat[2][6:0]), .tx(txl[2]), .txBusy(busy[2]), .txDone(done[2]), .fifo_level(lvl[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dbits(input int k);
    return (k == 0) ? 8 : 7;
  endfunction
  function automatic int pmode(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction
  function automatic int sbits(input int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic logic [7:0] dmask(input int k);
    return (k == 0) ? 8'hFF : 8'h7F;
  endfunction

  // Reference model: pending words per DUT, and the expected line waveform {done, tx} per future cycle
  logic [7:0] wq   [3][$];
  logic [1:0] line [3][$];
  bit         up;
  logic       m_acc;

  function automatic void build(input int k, input logic [7:0] d);
    bit seq[$];
    int ones;
    int total;
    seq.push_back(1'b0);
    for (int i = 0; i < dbits(k); i++) seq.push_back(d[i]);
    if (pmode(k) != 0) begin
      ones = $countones(d);
      seq.push_back((pmode(k) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1));
    end
    for (int i = 0; i < sbits(k); i++) seq.push_back(1'b1);
    total = seq.size() * DIV;
    for (int i = 0; i < total; i++)
      line[k].push_back({(i == total - 1) ? 1'b1 : 1'b0, seq[i / DIV]});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up = 1'b0;
      for (int k = 0; k < 3; k++) begin
        wq[k].delete();
        line[k].delete();
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_acc = vld[k] && up && txEn && (wq[k].size() < CAP);
        if (!txEn) begin
          wq[k].delete();
          line[k].delete();
        end else begin
          if (line[k].size() > 0) void'(line[k].pop_front());
          if (line[k].size() == 0 && wq[k].size() > 0) build(k, wq[k].pop_front());
          if (m_acc) wq[k].push_back(dat[k] & dmask(k));
        end
      end
      up = 1'b1;
    end
  end

  function automatic logic [1:0] exp_line(input int k);
    return (line[k].size() > 0) ? line[k][0] : 2'b01;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [1:0] e;
      e = exp_line(k);
      chk($sformatf("tx%0d", k),    txl[k],  e[0]);
      chk($sformatf("done%0d", k),  done[k], e[1]);
      chk($sformatf("busy%0d", k),  busy[k], line[k].size() > 0);
      chk($sformatf("level%0d", k), lvl[k],  wq[k].size());
      chk($sformatf("ready%0d", k), rdy[k],  up && txEn && (wq[k].size() < CAP));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    int n;
    n = 0;
    vld[k] = 1'b1;
    dat[k] = d;
    #1;
    while (!rdy[k] && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 2000) chk("push_wait", rdy[k], 1'b1);
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
  endtask

  logic [2:0] acc_r;

  initial begin
    rst_n = 1'b0;
    txEn  = 1'b1;
    vld   = '0;
    dat   = '0;
    step(3);
    chk("rst_ready", rdy[0], 1'b0);
    chk("rst_tx", txl[0], 1'b1);
    rst_n = 1'b1;
    step(2);

    push(0, 8'hA5);
    step(110);
    push(1, 8'h55);
    push(2, 8'h55);
    step(120);

    for (int i = 0; i < 6; i++) push(0, 8'($urandom));
    step(700);

    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    step(40);
    chk("abort_pre_busy", busy[0], 1'b1);
    txEn = 1'b0;
    step(1);
    chk("abort_tx", txl[0], 1'b1);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_level", lvl[0], 3'd0);
    chk("abort_done", done[0], 1'b0);
    txEn = 1'b1;
    push(0, 8'h3C);
    step(110);

    push(0, 8'hC3);
    step(92);
    chk("prerst_busy", busy[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", txl[0], 1'b1);
    chk("arst_busy", busy[0], 1'b0);
    chk("arst_done", done[0], 1'b0);
    chk("arst_level", lvl[0], 3'd0);
    chk("arst_ready", rdy[0], 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);

    for (int c = 0; c < 4000; c++) begin
      txEn = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < 3; k++) begin
        if (!vld[k] && $urandom_range(0, 2) == 0) begin
          vld[k] = 1'b1;
          dat[k] = 8'($urandom);
        end
      end
      #1;
      for (int k = 0; k < 3; k++) acc_r[k] = vld[k] && rdy[k];
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) if (acc_r[k]) vld[k] = 1'b0;
    end
    vld  = '0;
    txEn = 1'b1;
    step(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, successor to the fixed 8-bit sender. Adds configurable data width, parity, stop-bit count, an internal baud divider derived from parameters, and a ready/valid input with a transmit FIFO so software-side producers can queue bytes back-to-back. It sits between the bus-side register/DMA logic and the `tx` pad.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate; `DIV = CLK_FREQ / BAUD` (truncating), must be ≥2.
- `DATA_BITS`, 8: data bits per frame, 5–8.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `txEn`  in  1  block enable; low = synchronous flush/abort.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block accepts word this cycle.
- `in_data`  in  DATA_BITS  word to send.
- `tx`  out  1  serial line, idle high.
- `txBusy`  out  1  frame in progress.
- `txDone`  out  1  one-cycle pulse at end of each frame.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  queued words not yet started.

## Operation
- Reset values: `tx`=1, `txBusy`=0, `txDone`=0, `in_ready`=0, `fifo_level`=0; FSM IDLE, FIFO empty, baud counter 0.
- Push: word written on any edge with `in_valid && in_ready`. `in_ready = txEn && !full`; no pass-through when full, even if a pop occurs the same cycle. Push and pop in same cycle: both occur, level unchanged.
- FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE, or STOP → START directly when FIFO non-empty at end of stop.
- IDLE: if FIFO non-empty, pop head into shifter, `tx`←0, `txBusy`←1, counter←0, go START.
- Each bit lasts exactly `DIV` cycles; counter runs 0..DIV-1 and restarts at every frame start (no free-running phase).
- DATA: LSB first, `DATA_BITS` bits. PARITY state present only when `PARITY`≠0: odd → total ones (data+parity) odd; even → total even.
- STOP: `tx`=1 for `STOP_BITS×DIV` cycles. On final cycle `txDone` pulses; if FIFO non-empty pop and enter START (no idle gap, `txBusy` stays 1), else IDLE with `txBusy`←0.
- `txEn` low: next edge FSM→IDLE, `tx`←1, `txBusy`←0, FIFO cleared, no `txDone` for the aborted frame. Counter and shifter cleared.
- Async reset mid-frame: all outputs immediately to reset values.

## Timing
- Push at edge N into empty FIFO with FSM idle: pop at edge N+1, `tx` low from N+1.
- Frame length `DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)` cycles; `txDone` high during the last cycle of the last stop bit.
- `fifo_level` updates the edge after push/pop; popped word no longer counted.
- Back-to-back frames: next start bit begins the cycle after previous `txDone`.

## Configuration
- `UART_TX_FIFO_EN` defined: FIFO of `FIFO_DEPTH` entries as above.
- Not defined: FIFO replaced by one-entry holding register; `FIFO_DEPTH` ignored; `in_ready = txEn && !hold_valid`; `fifo_level` reports 0 or 1 in the LSB, upper bits 0. All other behaviour identical.

## Test plan
- CLK_FREQ=50000000, BAUD=5000000 (DIV=10), 8N1, push 0xA5 → `tx` 0,1,0,1,0,0,1,0,1,1 each 10 cycles; `txDone` one pulse 100 cycles after `tx` falls; `txBusy` 0 after.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x55 → start, 1,0,1,0,1,0,1, parity 0, two stop bits; frame 110 cycles. PARITY=1 → parity bit 1.
- FIFO_DEPTH=4, `in_valid` held with 6 words → 5 accepted on consecutive cycles, 6th stalls (`in_ready`=0, `fifo_level`=4) until first `txDone`; six frames contiguous, `txBusy` never drops between them.
- `txEn` dropped during data bit 3 with 2 words queued → next cycle `tx`=1, `txBusy`=0, `fifo_level`=0, no `txDone`; re-enable, push 0x3C → clean full frame.
- `rst_n` asserted mid-stop-bit → `tx`=1, `txBusy`=0, `txDone`=0, `fifo_level`=0 without waiting for a clock edge.
- Built without `UART_TX_FIFO_EN`: push 3 words back-to-back → first two accepted, third stalls until first `txDone`; frames correct.
